product_accumulator: RTL

- Downstream stage of the 32x32 signed multiplier (SAM). Consumes its 64-bit two's-complement products over a valid/ready stream.
- Accumulates products into groups delimited by `in_last`. Each finished sum is presented on a held output handshake.
- Overflow saturates the sum and is flagged.
- Forms the accumulate half of the team's MAC datapath.

---
 rtl/product_accumulator_if.sv | 40 ++++
 rtl/product_accumulator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
// Product stream in, group-sum stream out.
// Valid/ready handshake bundle for the MAC accumulate stage.
interface product_accumulator_if #(
  parameter int PW    = 64,
  parameter int CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_product;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] out_sum;
  logic                 out_sat;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_valid,
    output in_product,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_sat,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_sat,
    output out_count
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating group accumulator for signed multiplier products.
// Groups close on in_last; the sum is held until out_ready.
module product_accumulator #(
  parameter int PW    = 64,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [PW-1:0] SMAX =
    {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SMIN =
    {1'b1, {(PW-1){1'b0}}};
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             satf_q, satf_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic          beat;
  logic          hs;
  logic [PW:0]   sum_w;
  logic          ovf;
  logic [PW-1:0] sum_sat;

  assign beat = bus.in_valid & in_ready_q;
  assign hs   = out_valid_q & bus.out_ready;

  // One extra bit: overflow iff the top two bits differ
  assign sum_w = {acc_q[PW-1], acc_q}
               + {bus.in_product[PW-1], bus.in_product};
  assign ovf     = sum_w[PW] ^ sum_w[PW-1];
  assign sum_sat = ovf ? (sum_w[PW] ? SMIN : SMAX)
                       : sum_w[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM:
        if (beat) state_d = bus.in_last ? HOLD : ACCUM;
      HOLD:
        if (hs) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    satf_d = satf_q;
    if (beat) begin
      acc_d  = sum_sat;
      cnt_d  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
      satf_d = satf_q | ovf;
    end
    if (hs) begin
      acc_d  = '0;
      cnt_d  = '0;
      satf_d = 1'b0;
    end
  end

  // Outputs are registered from next state; zero outside HOLD
  always_comb begin
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
    out_sum_d   = out_valid_d ? acc_d : '0;
    out_sat_d   = out_valid_d & satf_d;
    out_count_d = out_valid_d ? cnt_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      satf_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      satf_q      <= satf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_count = out_count_q;

endmodule
